// File: rtl/intercal_alu_pkg.sv
// Shared op-codes, FSM state type and latency helper for the INTERCAL ALU.
package intercal_alu_pkg;

  localparam logic [3:0] OP_A           = 4'd0;
  localparam logic [3:0] OP_B           = 4'd1;
  localparam logic [3:0] OP_ANDH        = 4'd2;
  localparam logic [3:0] OP_AND         = 4'd3;
  localparam logic [3:0] OP_ORH         = 4'd4;
  localparam logic [3:0] OP_OR          = 4'd5;
  localparam logic [3:0] OP_XORH        = 4'd6;
  localparam logic [3:0] OP_XOR         = 4'd7;
  localparam logic [3:0] OP_MINGLE_LO   = 4'd8;
  localparam logic [3:0] OP_MINGLE_HI   = 4'd9;
  localparam logic [3:0] OP_SELH        = 4'd10;
  localparam logic [3:0] OP_SEL         = 4'd11;
  localparam logic [3:0] OP_ILLEGAL_MIN = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Cycles from accept to out_valid.
  function automatic int unsigned latency(input logic [3:0] op, input int unsigned width);
    if (op == OP_SEL)       return 1 + width;
    else if (op == OP_SELH) return 1 + width / 2;
    else                    return 1;
  endfunction

endpackage

// File: rtl/intercal_select_serial.sv
// Serial select engine: one mask bit per cycle, full width or two independent halves.
module intercal_select_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             split_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] m_i,
  output logic             done_o,
  output logic [WIDTH-1:0] res_o
);

  localparam int H  = WIDTH / 2;
  localparam int IW = $clog2(WIDTH);
  localparam int CW = IW + 1;

  logic [WIDTH-1:0] x_q, m_q, acc_q, acc_d;
  logic [CW-1:0]    cnt_q, plo_q, phi_q, plo_d, phi_d;
  logic             act_q, split_q;
  logic [CW-1:0]    last;
  logic [IW-1:0]    k_lo, k_hi, w_lo, w_hi;

  assign last   = split_q ? CW'(H - 1) : CW'(WIDTH - 1);
  assign done_o = act_q && (cnt_q == last);
  assign k_lo   = cnt_q[IW-1:0];
  assign k_hi   = k_lo + IW'(H);
  assign w_lo   = plo_q[IW-1:0];
  assign w_hi   = phi_q[IW-1:0] + IW'(H);

  // Low pointer serves the whole word in full mode; high pointer only in split mode.
  always_comb begin
    acc_d = acc_q;
    plo_d = plo_q;
    phi_d = phi_q;
    if (act_q) begin
      if (m_q[k_lo]) begin
        acc_d[w_lo] = x_q[k_lo];
        plo_d       = plo_q + CW'(1);
      end
      if (split_q && m_q[k_hi]) begin
        acc_d[w_hi] = x_q[k_hi];
        phi_d       = phi_q + CW'(1);
      end
    end
  end

  assign res_o = acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      plo_q   <= '0;
      phi_q   <= '0;
      act_q   <= 1'b0;
      split_q <= 1'b0;
    end else if (start_i) begin
      x_q     <= x_i;
      m_q     <= m_i;
      split_q <= split_i;
      acc_q   <= '0;
      cnt_q   <= '0;
      plo_q   <= '0;
      phi_q   <= '0;
      act_q   <= 1'b1;
    end else if (act_q) begin
      acc_q <= acc_d;
      plo_q <= plo_d;
      phi_q <= phi_d;
      if (done_o) act_q <= 1'b0;
      else        cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/intercal_alu_mc.sv
// Multi-cycle INTERCAL ALU: single-cycle unary/mingle ops, serial select, held result.
module intercal_alu_mc
  import intercal_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             err,
  output logic             busy
);

  localparam int H = WIDTH / 2;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             err_q, err_d;
  logic             accept, is_sel, sel_done;
  logic [WIDTH-1:0] sel_res;
  logic [WIDTH-1:0] rot_full, rot_half, mg_lo, mg_hi, alu_f;
  logic             alu_err;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign f         = f_q;
  assign err       = err_q;
  assign accept    = in_valid && in_ready;
  assign is_sel    = (op == OP_SEL) || (op == OP_SELH);

  // Rotate right by one inside the whole word, or inside each half independently.
  assign rot_full = {a[0], a[WIDTH-1:1]};
  assign rot_half = {a[H], a[WIDTH-1:H+1], a[0], a[H-1:1]};

  always_comb begin
    mg_lo = '0;
    mg_hi = '0;
    for (int i = 0; i < H; i++) begin
      mg_lo[2*i+1] = a[i];
      mg_lo[2*i]   = b[i];
      mg_hi[2*i+1] = a[H+i];
      mg_hi[2*i]   = b[H+i];
    end
  end

  always_comb begin
    alu_f   = '0;
    alu_err = (op >= OP_ILLEGAL_MIN);
    case (op)
      OP_A:         alu_f = a;
      OP_B:         alu_f = b;
      OP_ANDH:      alu_f = a & rot_half;
      OP_AND:       alu_f = a & rot_full;
      OP_ORH:       alu_f = a | rot_half;
      OP_OR:        alu_f = a | rot_full;
      OP_XORH:      alu_f = a ^ rot_half;
      OP_XOR:       alu_f = a ^ rot_full;
      OP_MINGLE_LO: alu_f = mg_lo;
      OP_MINGLE_HI: alu_f = mg_hi;
      default:      alu_f = '0;
    endcase
  end

  intercal_select_serial #(.WIDTH(WIDTH)) u_sel (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept && is_sel),
    .split_i (op == OP_SELH),
    .x_i     (a),
    .m_i     (b),
    .done_o  (sel_done),
    .res_o   (sel_res)
  );

  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        if (is_sel) begin
          state_d = ST_SEL;
        end else begin
          state_d = ST_DONE;
          f_d     = alu_f;
          err_d   = alu_err;
        end
      end
      ST_SEL: if (sel_done) begin
        state_d = ST_DONE;
        f_d     = sel_res;
        err_d   = 1'b0;
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      f_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_intercal_alu_mc.sv
// Randomized scoreboard bench for intercal_alu_mc against a bit-level reference model.
module tb_intercal_alu_mc;

  localparam int W = 32;
  localparam int H = W / 2;

  typedef struct {
    logic [W-1:0] f;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready, err, busy;
  logic [3:0]   op;
  logic [W-1:0] a, b, f;

  int   total, bad, cyc, ready_mode, hold_cnt;
  exp_t sbq[$];
  logic held, expect_idle;

  intercal_alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .f(f),
    .err(err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", n, act, expv, cyc);
    end
  endtask

  task automatic tfail(input string n);
    total++;
    bad++;
    $display("FAIL %s: got timeout want handshake (cycle %0d)", n, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] unary(input logic [W-1:0] x, input int n, input int kind);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < n; k++) begin
      case (kind)
        0:       r[k] = x[k] & x[(k+1) % n];
        1:       r[k] = x[k] | x[(k+1) % n];
        default: r[k] = x[k] ^ x[(k+1) % n];
      endcase
    end
    return r;
  endfunction

  function automatic logic [W-1:0] select(input logic [W-1:0] x, input logic [W-1:0] m, input int n);
    logic [W-1:0] r;
    int pos;
    r = '0;
    pos = 0;
    for (int k = 0; k < n; k++)
      if (m[k]) begin
        r[pos] = x[k];
        pos++;
      end
    return r;
  endfunction

  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [W-1:0] lo_mask;
    int kind, s;
    lo_mask = (W'(1) << H) - W'(1);
    e.err = 1'b0;
    e.f   = '0;
    e.lat = 1;
    e.acc = 0;
    kind  = (int'(o) - 2) / 2;
    if (o == 0) e.f = x;
    else if (o == 1) e.f = y;
    else if (o <= 7) begin
      if (o[0]) e.f = unary(x, W, kind);
      else e.f = (unary(x >> H, H, kind) << H) | unary(x & lo_mask, H, kind);
    end else if (o <= 9) begin
      s = (o == 9) ? H : 0;
      for (int i = 0; i < H; i++) begin
        e.f[2*i+1] = x[s+i];
        e.f[2*i]   = y[s+i];
      end
    end else if (o == 10) begin
      e.f   = (select(x >> H, y >> H, H) << H) | select(x & lo_mask, y & lo_mask, H);
      e.lat = 1 + H;
    end else if (o == 11) begin
      e.f   = select(x, y, W);
      e.lat = 1 + W;
    end else begin
      e.err = 1'b1;
    end
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e_in);
    exp_t e;
    int n;
    e = e_in;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tfail("wait_in_ready");
      return;
    end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1;
    e.acc = cyc;
    sbq.push_back(e);
    n = 0;
    // Junk on the inputs while busy must be ignored.
    while (1) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        in_valid = 1'b0;
        break;
      end
      if (n >= 400) begin
        in_valid = 1'b0;
        tfail("wait_result");
        break;
      end
      in_valid = 1'($urandom);
      op = 4'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      n++;
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    send(o, x, y, model(o, x, y));
  endtask

  task automatic issue_dir(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] fx, input logic ex, input int lat);
    exp_t e;
    e.f = fx; e.err = ex; e.lat = lat; e.acc = 0;
    send(o, x, y, e);
  endtask

  // ---------------- consumer ----------------
  initial begin
    out_ready = 1'b0;
    hold_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid) hold_cnt++;
      else hold_cnt = 0;
      case (ready_mode)
        0:       out_ready = ($urandom % 3) != 0;
        1:       out_ready = hold_cnt > 5;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    held = 1'b0;
    expect_idle = 1'b0;
  end

  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
      expect_idle = 1'b0;
    end else begin
      if (expect_idle) begin
        chk("in_ready_after_release", 64'(in_ready), 64'(1));
        expect_idle = 1'b0;
      end
      if (out_valid) begin
        if (sbq.size() == 0) chk("spurious_out_valid", 64'(out_valid), 64'(0));
        else begin
          if (!held) chk("latency", 64'(cyc - sbq[0].acc + 1), 64'(sbq[0].lat));
          chk("f", 64'(f), 64'(sbq[0].f));
          chk("err", 64'(err), 64'(sbq[0].err));
          chk("in_ready_in_done", 64'(in_ready), 64'(0));
          chk("busy_in_done", 64'(busy), 64'(1));
          if (out_ready) begin
            void'(sbq.pop_front());
            held = 1'b0;
            expect_idle = 1'b1;
          end else begin
            held = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [W-1:0] rb;
    total = 0; bad = 0; ready_mode = 2;
    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_f", 64'(f), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    rst = 1'b0;

    issue_dir(4'd3,  32'h0000_0003, 32'h0,          32'h0000_0001, 1'b0, 1);
    issue_dir(4'd8,  32'h0000_FFFF, 32'h0,          32'hAAAA_AAAA, 1'b0, 1);
    issue_dir(4'd9,  32'hFFFF_0000, 32'h0,          32'hAAAA_AAAA, 1'b0, 1);
    issue_dir(4'd11, 32'h1234_5678, 32'h0000_FFFF,  32'h0000_5678, 1'b0, 33);
    issue_dir(4'd11, 32'h1234_5678, 32'h0,          32'h0,         1'b0, 33);
    issue_dir(4'd10, 32'hFFFF_FFFF, 32'h8001_0003,  32'h0003_0003, 1'b0, 17);
    issue_dir(4'd11, 32'hDEAD_BEEF, 32'hFFFF_FFFF,  32'hDEAD_BEEF, 1'b0, 33);

    ready_mode = 1;
    issue(4'd5, W'($urandom), W'($urandom));
    issue(4'd10, W'($urandom), W'($urandom));

    // Reset in the tenth SEL cycle of a full-width select.
    ready_mode = 2;
    @(negedge clk);
    op = 4'd11; a = 32'hCAFE_F00D; b = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("busy_before_rst", 64'(busy), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_f", 64'(f), 64'(0));
    chk("abort_err", 64'(err), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 64'(out_valid), 64'(0));
    end
    issue_dir(4'd13, W'($urandom), W'($urandom), 32'h0, 1'b1, 1);

    ready_mode = 0;
    for (int i = 0; i < 150; i++) begin
      case ($urandom % 4)
        0:       rb = '0;
        1:       rb = '1;
        default: rb = W'($urandom);
      endcase
      issue(4'($urandom_range(0, 15)), W'($urandom), rb);
    end

    n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) tfail("drain");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
